// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared opcodes, FSM encoding and timeout default
// for the two-port ALU job arbiter.
package alu_arb_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [3:0] OP_HOLD = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_ONES = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SBB  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_ADC  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_XOR  = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_RESP
  } state_t;

  function automatic logic op_ok(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant with priority register.
// req[1:0] in, gnt_id out; done/done_id rotate priority.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       gnt_id
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_id = 1'b0;
    unique case (req)
      2'b11:   gnt_id = prio_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  // prio_q names the port that wins a tie
  always_comb begin
    prio_d = prio_q;
    if (done) prio_d = ~done_id;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: serves multi-beat ALU jobs from two requesters.
// Ports: r0_*/r1_* beat handshakes, alu_* ALU side, rsp_* result.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        r0_valid,
  input  logic [3:0]  r0_op,
  input  logic [15:0] r0_data,
  input  logic        r0_last,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [3:0]  r1_op,
  input  logic [15:0] r1_data,
  input  logic        r1_last,
  output logic        r1_ready,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_data,
  input  logic [31:0] alu_result,
  input  logic        alu_status,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_status,
  output logic        rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        gnt_id;
  logic        run;
  logic        accept;
  logic        own_valid;
  logic        own_last;
  logic [3:0]  own_op;
  logic [15:0] own_data;

  assign run       = state_q == ST_RUN;
  assign r0_ready  = run & ~owner_q;
  assign r1_ready  = run & owner_q;
  assign own_valid = owner_q ? r1_valid : r0_valid;
  assign own_last  = owner_q ? r1_last : r0_last;
  assign own_op    = owner_q ? r1_op : r0_op;
  assign own_data  = owner_q ? r1_data : r0_data;
  assign accept    = run & own_valid;

  assign alu_opcode = op_q;
  assign alu_data   = data_q;

  // response fields are live ALU values gated by RESP
  assign rsp_valid  = state_q == ST_RESP;
  assign rsp_id     = rsp_valid & owner_q;
  assign rsp_result = rsp_valid ? alu_result : 32'd0;
  assign rsp_status = rsp_valid & alu_status;
  assign rsp_err    = rsp_valid & err_q;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .rstb    (rstb),
    .req     ({r1_valid, r0_valid}),
    .done    (rsp_valid),
    .done_id (owner_q),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = OP_HOLD;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (r0_valid | r1_valid) begin
          owner_d = gnt_id;
          op_d    = OP_CLR;
          data_d  = 16'd0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          // bad opcodes still consume the beat
          op_d   = op_ok(own_op) ? own_op : OP_HOLD;
          data_d = own_data;
          err_d  = err_q | ~op_ok(own_op);
          cnt_d  = '0;
          if (own_last) state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      op_q    <= OP_HOLD;
      data_q  <= 16'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a
// behavioural accumulator ALU on the alu_* side.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic        v[2];
  logic        l[2];
  logic [3:0]  o[2];
  logic [15:0] d[2];

  logic        r0_ready, r1_ready;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_data;
  logic [31:0] alu_result;
  logic        alu_status;
  logic        rsp_valid, rsp_id, rsp_status, rsp_err;
  logic [31:0] rsp_result;

  alu_arbiter dut (
    .clk        (clk),
    .rstb       (rstb),
    .r0_valid   (v[0]),
    .r0_op      (o[0]),
    .r0_data    (d[0]),
    .r0_last    (l[0]),
    .r0_ready   (r0_ready),
    .r1_valid   (v[1]),
    .r1_op      (o[1]),
    .r1_data    (d[1]),
    .r1_last    (l[1]),
    .r1_ready   (r1_ready),
    .alu_opcode (alu_opcode),
    .alu_data   (alu_data),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .rsp_err    (rsp_err)
  );

  // ALU stand-in: mul multiplies by the previous operand
  typedef struct packed {
    logic [31:0] acc;
    logic        cy;
    logic [15:0] b;
  } alu_st_t;

  function automatic alu_st_t alu_f(input alu_st_t s,
                                    input logic [3:0] op,
                                    input logic [15:0] x);
    alu_st_t n;
    logic [32:0] t;
    logic [31:0] xe;
    n  = s;
    xe = {16'd0, x};
    t  = '0;
    case (op)
      OP_CLR: begin n.acc = '0; n.b = '0; end
      OP_ONES: n.acc = '1;
      OP_DIV: if (x != 0) n.acc = s.acc / xe;
      OP_SUB: t = {1'b0, s.acc} - {1'b0, xe};
      OP_SBB: t = {1'b0, s.acc} - {1'b0, xe} - {32'd0, s.cy};
      OP_ADD: t = {1'b0, s.acc} + {1'b0, xe};
      OP_ADC: t = {1'b0, s.acc} + {1'b0, xe} + {32'd0, s.cy};
      OP_MUL: n.acc = {16'd0, s.b} * xe;
      OP_AND: n.acc = s.acc & xe;
      OP_OR:  n.acc = s.acc | xe;
      OP_NOT: n.acc = ~s.acc;
      OP_XOR: n.acc = s.acc ^ xe;
      default: ;
    endcase
    if (op inside {OP_SUB, OP_SBB, OP_ADD, OP_ADC}) begin
      n.acc = t[31:0];
      n.cy  = t[32];
    end
    if (op != OP_HOLD && op != OP_CLR) n.b = x;
    return n;
  endfunction

  alu_st_t alu_s = '0;
  always @(posedge clk) alu_s <= alu_f(alu_s, alu_opcode, alu_data);
  assign alu_result = alu_s.acc;
  assign alu_status = alu_s.cy;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        st;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  alu_st_t    m = '0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rsp_cnt = 0;
  int         rsp_cyc = 0;
  logic [3:0] op_log[$];
  bit         both_rdy = 0;

  logic [3:0]  jop[2][8];
  logic [15:0] jd[2][8];
  int          jn[2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (alu_opcode != 4'd0) op_log.push_back(alu_opcode);
    if (r0_ready && r1_ready) both_rdy = 1;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected id=%0d res=%0d", rsp_id,
                 rsp_result);
      end else begin
        e = sbq.pop_front();
        if ({rsp_id, rsp_result, rsp_status, rsp_err} !==
            {e.id, e.res, e.st, e.err}) begin
          fails++;
          $display("FAIL rsp got id=%0d res=%0d st=%0d err=%0d %s",
                   rsp_id, rsp_result, rsp_status, rsp_err,
                   $sformatf("want id=%0d res=%0d st=%0d err=%0d",
                             e.id, e.res, e.st, e.err));
        end
      end
    end
  end

  function automatic logic rdy(input int p);
    return (p != 0) ? r1_ready : r0_ready;
  endfunction

  task automatic set_beat(input int p, input int i,
                          input logic [3:0] op,
                          input logic [15:0] x);
    jop[p][i] = op;
    jd[p][i]  = x;
    jn[p]     = i + 1;
  endtask

  // predicted response in service order; to = timeout abort
  task automatic expect_job(input int p, input bit to);
    exp_t e;
    bit er;
    logic [3:0] op;
    er = to;
    m  = alu_f(m, OP_CLR, 16'd0);
    for (int i = 0; i < jn[p]; i++) begin
      op = jop[p][i];
      if (op > 4'd12) begin
        er = 1;
        op = OP_HOLD;
      end
      m = alu_f(m, op, jd[p][i]);
    end
    e.id  = p[0];
    e.res = m.acc;
    e.st  = m.cy;
    e.err = er;
    sbq.push_back(e);
  endtask

  task automatic run_port(input int p, input bit no_last,
                          output int lc);
    int k;
    lc = 0;
    for (int i = 0; i < jn[p]; i++) begin
      v[p] = 1'b1;
      o[p] = jop[p][i];
      d[p] = jd[p][i];
      l[p] = (i == jn[p] - 1) && !no_last;
      k = 0;
      @(negedge clk);
      while (!rdy(p) && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (!rdy(p)) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout port=%0d beat=%0d", p, i);
        break;
      end
      lc = cyc;
      @(posedge clk);
      #1;
    end
    v[p] = 1'b0;
    l[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (rsp_cnt < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (rsp_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout got=%0d want=%0d", rsp_cnt, target);
    end
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    #3;
    tests += 5;
    if (alu_opcode !== 4'd0) begin
      fails++;
      $display("FAIL rst_opcode got=%0d want=0", alu_opcode);
    end
    if (alu_data !== 16'd0) begin
      fails++;
      $display("FAIL rst_data got=%0d want=0", alu_data);
    end
    if ({r0_ready, r1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL rst_ready got=%b want=00", {r0_ready, r1_ready});
    end
    if ({rsp_valid, rsp_id, rsp_status, rsp_err} !== 4'b0) begin
      fails++;
      $display("FAIL rst_rsp_flags got=%b want=0000",
               {rsp_valid, rsp_id, rsp_status, rsp_err});
    end
    if (rsp_result !== 32'd0) begin
      fails++;
      $display("FAIL rst_result got=%0d want=0", rsp_result);
    end
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie;
    int base, lc0, lc1;
    base = rsp_cnt;
    set_beat(0, 0, OP_ADD, 16'd1);
    set_beat(1, 0, OP_ADD, 16'd2);
    set_beat(1, 1, OP_ADD, 16'd3);
    expect_job(0, 0);
    expect_job(1, 0);
    both_rdy = 0;
    fork
      run_port(0, 0, lc0);
      run_port(1, 0, lc1);
    join
    wait_rsp(base + 2);
    tests++;
    if (both_rdy !== 1'b0) begin
      fails++;
      $display("FAIL tie_both_ready got=1 want=0");
    end
  endtask

  task automatic test_basic;
    int base, lc;
    base = rsp_cnt;
    op_log.delete();
    set_beat(0, 0, OP_ADD, 16'd5);
    set_beat(0, 1, OP_ADD, 16'd7);
    expect_job(0, 0);
    run_port(0, 0, lc);
    wait_rsp(base + 1);
    tests += 3;
    if (op_log.size() != 3) begin
      fails++;
      $display("FAIL basic_log_len got=%0d want=3", op_log.size());
    end else if (op_log[0] !== 4'd1 || op_log[1] !== 4'd6 ||
                 op_log[2] !== 4'd6) begin
      fails++;
      $display("FAIL basic_log got=%0d,%0d,%0d want=1,6,6",
               op_log[0], op_log[1], op_log[2]);
    end
    if (rsp_cyc !== lc + 2) begin
      fails++;
      $display("FAIL basic_latency got=%0d want=%0d", rsp_cyc, lc + 2);
    end
    if (alu_opcode !== 4'd0) begin
      fails++;
      $display("FAIL idle_opcode got=%0d want=0", alu_opcode);
    end
  endtask

  task automatic test_back_to_back;
    int base, lc0, lc1;
    base = rsp_cnt;
    set_beat(1, 0, OP_ONES, 16'd0);
    set_beat(1, 1, OP_ADD, 16'd1);
    set_beat(0, 0, OP_ADD, 16'd10);
    set_beat(0, 1, OP_SUB, 16'd4);
    expect_job(1, 0);
    expect_job(0, 0);
    fork
      run_port(0, 0, lc0);
      run_port(1, 0, lc1);
    join
    wait_rsp(base + 2);
  endtask

  task automatic test_mul;
    int base, lc;
    base = rsp_cnt;
    set_beat(1, 0, OP_MUL, 16'd300);
    set_beat(1, 1, OP_MUL, 16'd300);
    expect_job(1, 0);
    run_port(1, 0, lc);
    wait_rsp(base + 1);
  endtask

  task automatic test_timeout;
    int base, lc;
    base = rsp_cnt;
    set_beat(0, 0, OP_ADD, 16'd3);
    expect_job(0, 1);
    run_port(0, 1, lc);
    wait_rsp(base + 1);
    tests++;
    if (rsp_cyc !== lc + 18) begin
      fails++;
      $display("FAIL timeout_cycle got=%0d want=%0d", rsp_cyc,
               lc + 18);
    end
  endtask

  task automatic test_invalid;
    int base, lc;
    base = rsp_cnt;
    op_log.delete();
    set_beat(1, 0, 4'd14, 16'd9);
    expect_job(1, 0);
    run_port(1, 0, lc);
    wait_rsp(base + 1);
    tests++;
    if (op_log.size() != 1) begin
      fails++;
      $display("FAIL invalid_log_len got=%0d want=1", op_log.size());
    end
    set_beat(0, 0, 4'd13, 16'd1);
    set_beat(0, 1, OP_ADD, 16'd4);
    expect_job(0, 0);
    run_port(0, 0, lc);
    wait_rsp(base + 2);
  endtask

  task automatic test_reset_mid;
    int base, k, lc0, lc1;
    base = rsp_cnt;
    v[0] = 1'b1;
    o[0] = OP_ADD;
    d[0] = 16'd5;
    l[0] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!r0_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (alu_opcode !== OP_ADD) begin
      fails++;
      $display("FAIL mid_pre_opcode got=%0d want=6", alu_opcode);
    end
    #2;
    rstb = 1'b0;
    #1;
    tests += 5;
    if (alu_opcode !== 4'd0) begin
      fails++;
      $display("FAIL mid_opcode got=%0d want=0", alu_opcode);
    end
    if (alu_data !== 16'd0) begin
      fails++;
      $display("FAIL mid_data got=%0d want=0", alu_data);
    end
    if ({r0_ready, r1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL mid_ready got=%b want=00", {r0_ready, r1_ready});
    end
    if ({rsp_valid, rsp_id, rsp_status, rsp_err} !== 4'b0) begin
      fails++;
      $display("FAIL mid_rsp_flags got=%b want=0000",
               {rsp_valid, rsp_id, rsp_status, rsp_err});
    end
    if (rsp_result !== 32'd0) begin
      fails++;
      $display("FAIL mid_result got=%0d want=0", rsp_result);
    end
    v[0] = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (rsp_cnt !== base) begin
      fails++;
      $display("FAIL mid_no_rsp got=%0d want=%0d", rsp_cnt, base);
    end
    op_log.delete();
    set_beat(0, 0, OP_ADD, 16'd2);
    set_beat(1, 0, OP_XOR, 16'h00ff);
    expect_job(0, 0);
    expect_job(1, 0);
    fork
      run_port(0, 0, lc0);
      run_port(1, 0, lc1);
    join
    wait_rsp(base + 2);
    tests++;
    if (op_log.size() == 0 || op_log[0] !== OP_CLR) begin
      fails++;
      $display("FAIL mid_restart_clr got=%0d want=1",
               op_log.size() == 0 ? 0 : op_log[0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0;
      l[p] = 1'b0;
      o[p] = 4'd0;
      d[p] = 16'd0;
      jn[p] = 0;
    end
    test_reset;
    test_tie;
    test_basic;
    test_back_to_back;
    test_mul;
    test_timeout;
    test_invalid;
    test_reset_mid;
    repeat (3) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d want=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
